// File: rtl/ahb_sram_slave_if.sv
// Bus bundle for ahb_sram_slave: the AHB-Lite slave port plus the
// start/io_done request handshake toward sram_iface.
interface ahb_sram_slave_if #(
  parameter int ADDR_BITS = 16
);
  logic                 HSEL;
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [31:0]          HWDATA;
  logic                 HREADY;
  logic                 HREADYOUT;
  logic                 HRESP;
  logic [31:0]          HRDATA;
  logic                 start;
  logic                 writemode;
  logic [ADDR_BITS-1:0] i_address;
  logic [31:0]          i_w_data;
  logic [31:0]          i_r_data;
  logic                 io_done;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output start, writemode, i_address, i_w_data,
    input  i_r_data, io_done
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  start, writemode, i_address, i_w_data,
    output i_r_data, io_done
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word slave that turns each legal transfer into one start/io_done
// request to sram_iface and answers illegal transfers with a two-cycle ERROR.
//
// state  | meaning
// IDLE   | no transfer in progress; zero-wait OKAY, samples address phases
// REQ    | first data-phase cycle; start pulse, HWDATA captured for writes
// WAIT   | waiting for io_done; read data captured on the io_done cycle
// DONE   | transfer complete; OKAY with HRDATA valid, samples next phase
// ERR1   | first ERROR cycle (HREADYOUT low)
// ERR2   | second ERROR cycle (HREADYOUT high); address phases ignored
module ahb_sram_slave #(
  parameter int ADDR_BITS = 16
) (
  input logic             clk,
  input logic             n_rst,
  ahb_sram_slave_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t               state_q;
  logic                 hreadyout_q;
  logic                 hresp_q;
  logic [31:0]          hrdata_q;
  logic                 start_q;
  logic                 writemode_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;

  logic addr_valid_d;
  logic addr_legal_d;
  logic unused_htrans0;

  // HTRANS[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
  assign addr_valid_d   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign addr_legal_d   = (bus.HSIZE == 3'b010) && (bus.HADDR[1:0] == 2'b00) &&
                          (bus.HADDR[31:ADDR_BITS+2] == '0);
  assign unused_htrans0 = bus.HTRANS[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      start_q     <= 1'b0;
      writemode_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (addr_valid_d) begin
            hreadyout_q <= 1'b0;
            if (addr_legal_d) begin
              state_q     <= S_REQ;
              start_q     <= 1'b1;
              writemode_q <= bus.HWRITE;
              addr_q      <= bus.HADDR[ADDR_BITS+1:2];
            end else begin
              state_q <= S_ERR1;
              hresp_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (writemode_q) wdata_q <= bus.HWDATA;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.io_done) begin
            if (!writemode_q) hrdata_q <= bus.i_r_data;
            hreadyout_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_ERR1: begin
          hreadyout_q <= 1'b1;
          state_q     <= S_ERR2;
        end
        S_ERR2: begin
          hresp_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.start     = start_q;
  assign bus.writemode = writemode_q;
  assign bus.i_address = addr_q;
  assign bus.i_w_data  = wdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised scoreboard bench for ahb_sram_slave: an AHB master driver, an
// SRAM responder model and a response monitor checked against a word-memory model.
module tb_ahb_sram_slave;
  localparam int AB = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave_if #(.ADDR_BITS(AB)) bus ();

  ahb_sram_slave #(.ADDR_BITS(AB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  // single-slave fabric: HREADY follows this slave's HREADYOUT
  assign bus.HREADY = bus.HREADYOUT;

  logic        io_done_r = 1'b0;
  logic [31:0] rdata_r   = 32'h0;
  assign bus.io_done  = io_done_r;
  assign bus.i_r_data = rdata_r;

  typedef struct {
    logic        err;
    logic [31:0] hrdata;
    int          waits;
  } bus_exp_t;

  typedef struct {
    logic          wr;
    logic [AB-1:0] addr;
    logic [31:0]   wdata;
    int            d;
    int            hold;
  } req_exp_t;

  bus_exp_t    bus_q[$];
  req_exp_t    req_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] sram_mem[int];
  logic [31:0] last_read = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
  endfunction

  // SRAM responder: io_done d cycles after start, held for 'hold' cycles
  req_exp_t cur;
  logic     busy = 1'b0;
  int       cnt = 0;
  int       hold_c = 0;
  always @(negedge clk) begin
    if (!n_rst) begin
      busy = 1'b0;
      cnt = 0;
      hold_c = 0;
      io_done_r = 1'b0;
    end else begin
      if (io_done_r) begin
        hold_c--;
        if (hold_c <= 0) begin
          io_done_r = 1'b0;
          rdata_r = $urandom;
        end
      end else begin
        rdata_r = $urandom;
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          chk("writemode_stable", bus.writemode, cur.wr);
          chk("i_address_stable", bus.i_address, cur.addr);
          if (cur.wr) begin
            chk("i_w_data", bus.i_w_data, cur.wdata);
            sram_mem[int'(cur.addr)] = bus.i_w_data;
          end else begin
            rdata_r = sram_rd(int'(cur.addr));
          end
          io_done_r = 1'b1;
          hold_c = cur.hold;
          busy = 1'b0;
        end
      end
      if (bus.start === 1'b1) begin
        chk("start_while_busy", busy, 1'b0);
        chk("start_expected", req_q.size() != 0, 1'b1);
        if (req_q.size() != 0) begin
          cur = req_q.pop_front();
          chk("writemode", bus.writemode, cur.wr);
          chk("i_address", bus.i_address, cur.addr);
          busy = 1'b1;
          cnt = cur.d;
        end
      end
    end
  end

  // response monitor: a completed data phase is HREADYOUT returning high
  int   low_cnt = 0;
  logic resp_first = 1'b0;
  bus_exp_t be_m;
  always @(negedge clk) begin
    if (!n_rst) begin
      low_cnt = 0;
    end else if (bus.HREADYOUT !== 1'b1) begin
      if (low_cnt == 0) resp_first = bus.HRESP;
      low_cnt++;
    end else if (low_cnt > 0) begin
      chk("response_expected", bus_q.size() != 0, 1'b1);
      if (bus_q.size() != 0) begin
        be_m = bus_q.pop_front();
        chk("hresp_first", resp_first, be_m.err);
        chk("hresp_last", bus.HRESP, be_m.err);
        chk("wait_states", low_cnt, be_m.waits);
        chk("hrdata", bus.HRDATA, be_m.hrdata);
      end
      low_cnt = 0;
    end
  end

  task automatic idle_cycle();
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    @(posedge clk);
    #1;
  endtask

  // presents one address phase; returns in the DONE/ERR2 cycle (or one cycle later if not a transfer)
  task automatic issue(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                       input int d, input int hold, input logic ignored, output logic err);
    logic valid, legal;
    int wa;
    bus_exp_t be;
    req_exp_t re;
    err = 1'b0;
    bus.HSEL = sel;
    bus.HTRANS = trans;
    bus.HADDR = addr;
    bus.HWRITE = wr;
    bus.HSIZE = size;
    valid = sel && trans[1] && !ignored;
    legal = (size == 3'b010) && (addr % 4 == 0) && ({32'h0, addr} < (64'd1 << (AB + 2)));
    if (valid) begin
      wa = int'(addr / 4);
      if (legal) begin
        if (wr) begin
          be = '{1'b0, last_read, d + 1};
          ref_mem[wa] = wdata;
        end else begin
          last_read = ref_rd(wa);
          be = '{1'b0, last_read, d + 1};
        end
        re = '{wr, addr[AB+1:2], wdata, d, hold};
        req_q.push_back(re);
      end else begin
        be = '{1'b1, last_read, 1};
      end
      bus_q.push_back(be);
    end
    @(posedge clk);
    #1;
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = wdata;
    if (valid) begin
      int n = 0;
      while (bus.HREADYOUT !== 1'b1 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (bus.HREADYOUT !== 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL hreadyout_timeout: HREADYOUT still %b after %0d cycles", bus.HREADYOUT, n);
        abort = 1'b1;
      end
      err = !legal;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, bus.HREADYOUT, 1'b1);
    chk({tag, "_hresp"}, bus.HRESP, 1'b0);
    chk({tag, "_hrdata"}, bus.HRDATA, 32'h0);
    chk({tag, "_start"}, bus.start, 1'b0);
    chk({tag, "_writemode"}, bus.writemode, 1'b0);
    chk({tag, "_i_address"}, bus.i_address, 32'h0);
    chk({tag, "_i_w_data"}, bus.i_w_data, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic err;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic        sel;
    int          r;
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR = 32'h0;
    bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010;
    bus.HWDATA = 32'h0;
    ref_mem[1] = 32'h12345678;
    sram_mem[1] = 32'h12345678;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b1, 2'b10, 32'h3E8, 1'b1, 3'b010, 32'hAB, 2, 1, 1'b0, err);
    idle_cycle();
    idle_cycle();
    chk("sram_dump_0xFA", sram_rd(32'hFA), 32'hAB);

    issue(1'b1, 2'b10, 32'h4, 1'b0, 3'b010, 32'h0, 1, 1, 1'b0, err);
    idle_cycle();

    issue(1'b1, 2'b10, 32'h3EC, 1'b1, 3'b010, 32'hCD, 1, 2, 1'b0, err);
    issue(1'b1, 2'b10, 32'h3EC, 1'b0, 3'b010, 32'h0, 1, 1, 1'b0, err);
    idle_cycle();

    issue(1'b1, 2'b10, 32'h8, 1'b0, 3'b000, 32'h0, 1, 1, 1'b0, err);
    issue(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'hDEAD, 1, 1, 1'b1, err);
    issue(1'b1, 2'b10, 32'h40000, 1'b0, 3'b010, 32'h0, 1, 1, 1'b0, err);
    idle_cycle();
    issue(1'b1, 2'b10, 32'h2, 1'b1, 3'b010, 32'h77, 1, 1, 1'b0, err);
    idle_cycle();

    issue(1'b1, 2'b00, 32'h20, 1'b1, 3'b010, 32'h1, 1, 1, 1'b0, err);
    issue(1'b1, 2'b01, 32'h24, 1'b0, 3'b010, 32'h2, 1, 1, 1'b0, err);
    issue(1'b0, 2'b10, 32'h28, 1'b1, 3'b010, 32'h3, 1, 1, 1'b0, err);
    idle_cycle();

    for (int i = 0; i < 150 && !abort; i++) begin
      r = $urandom_range(0, 99);
      sel = 1'b1;
      trans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      size = 3'b010;
      addr = $urandom_range(0, 63) * 4;
      if (r < 10) begin
        size = 3'($urandom_range(0, 7));
        if (size == 3'b010) size = 3'b000;
      end else if (r < 15) begin
        addr = addr | 32'($urandom_range(1, 3));
      end else if (r < 20) begin
        addr = addr | (32'h1 << $urandom_range(AB + 2, 31));
      end else if (r < 25) begin
        trans = 2'($urandom_range(0, 1));
      end else if (r < 28) begin
        sel = 1'b0;
      end
      issue(sel, trans, addr, 1'($urandom_range(0, 1)), size, $urandom,
            $urandom_range(1, 4), $urandom_range(1, 2), 1'b0, err);
      if (err) begin
        if ($urandom_range(0, 1) == 1)
          issue(1'b1, 2'b10, 32'h0, 1'b1, 3'b010, $urandom, 1, 1, 1'b1, err);
        else
          idle_cycle();
      end else if ($urandom_range(0, 1) == 1) begin
        idle_cycle();
      end
    end

    repeat (5) idle_cycle();
    chk("bus_q_drained", bus_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);

    // asynchronous reset in the REQ cycle of a write
    bus.HSEL = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR = 32'h3C;
    bus.HWRITE = 1'b1;
    bus.HSIZE = 3'b010;
    @(posedge clk);
    #1;
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    chk("start_before_reset", bus.start, 1'b1);
    #1;
    n_rst = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave that terminates bus transfers issued by the ARM master and converts each accepted word transfer into one request on the `sram_iface` start/`io_done` handshake toward the off-chip SRAM. It is the responder end of the ARM's AHB traffic. It sits between the AHB fabric and `sram_iface`, so the processor can load and dump image memory through the bus instead of through testbench strobes.

## Interface
- ADDR_BITS, 16, SRAM word-address width; must match `sram_iface` `i_address`.
- clk  in  1  system clock; all logic rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
- HWDATA  in  32  write data, valid during the data phase.
- HREADY  in  1  fabric ready; an address phase is sampled only when this is 1.
- HREADYOUT  out  1  slave ready; 0 inserts wait states.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data, registered.
- start  out  1  one-cycle request pulse to `sram_iface`.
- writemode  out  1  1 = write request.
- i_address  out  ADDR_BITS  SRAM word address = HADDR[ADDR_BITS+1:2].
- i_w_data  out  32  write data to `sram_iface`.
- i_r_data  in  32  read data from `sram_iface`, valid when io_done=1.
- io_done  in  1  request complete, one cycle or more.

## Operation
- **Valid address phase:** HSEL & HREADY & HTRANS[1] at a rising edge, sampled only in IDLE or DONE.
- **Legal transfer:** HSIZE==3'b010, HADDR[1:0]==0, and HADDR[31:ADDR_BITS+2]==0. Anything else is illegal.
- **Bus-side states:** IDLE, REQ, WAIT, DONE, ERR1, ERR2.
- **IDLE:** HREADYOUT=1, HRESP=0.
  - Valid legal phase: latch address and HWRITE, go to REQ.
  - Valid illegal phase: go to ERR1.
  - Anything else, including HTRANS IDLE/BUSY: stay in IDLE; the bus sees a zero-wait OKAY.
- **REQ** (first data-phase cycle): HREADYOUT=0.
  - start=1 for exactly this cycle.
  - writemode and i_address take their latched values.
  - For writes, i_w_data is loaded from HWDATA at the end of this cycle.
  - Go to WAIT.
- **WAIT:** HREADYOUT=0; start=0.
  - writemode, i_address and i_w_data stay stable.
  - When io_done=1: for reads, capture i_r_data into HRDATA; go to DONE.
  - io_done is ignored in every state except WAIT.
- **DONE:** HREADYOUT=1, HRESP=0. Next-state decision is the same as in IDLE, so a pipelined back-to-back transfer is accepted in this cycle.
- **ERR1:** HREADYOUT=0, HRESP=1. Go to ERR2.
- **ERR2:** HREADYOUT=1, HRESP=1.
  - Next state is IDLE.
  - An address phase presented during ERR2 is ignored: the master cancels on ERROR.
  - No start is issued for an illegal transfer.
- **Register behaviour:**
  - HRDATA holds the last read value; writes and errors leave it unchanged.
  - i_address, i_w_data and writemode hold their values between transfers.

## Timing
- **Reset values:** state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, start=0, writemode=0, i_address=0, i_w_data=0. All outputs are registered.
- **Latency:** address edge, then REQ (1 cycle), then WAIT (N≥1 cycles, ending with the io_done cycle), then DONE.
  - Data-phase wait states = N+1.
  - Minimum total data phase is 3 cycles, with io_done in the first WAIT cycle.
- **Throughput:** back-to-back transfers give one start every N+2 cycles.
- **HRDATA:** valid in the DONE cycle, i.e. the cycle HREADYOUT returns to 1.
- **Reset mid-transfer:** asynchronous return to IDLE with all reset values. `sram_iface` shares n_rst, so the outstanding request is abandoned and a stale io_done cannot occur.
- **io_done held high across several cycles:** only the first cycle in WAIT counts.

## Test plan
- **Reset:** assert n_rst=0 mid-stream. Required: HREADYOUT=1, HRESP=0, HRDATA=0, start=0, writemode=0, i_address=0, i_w_data=0, all immediately (asynchronously).
- **Single write:** HADDR=0x3E8, HWRITE=1, HWDATA=0xAB, io_done returned 2 cycles after start. Required: one start pulse, writemode=1, i_address=0x00FA, i_w_data=0x000000AB, HREADYOUT low for 3 cycles, then OKAY; SRAM dump shows word 0xFA = 0xAB.
- **Single read:** HADDR=0x4, HWRITE=0, io_done with i_r_data=0x12345678 in the first WAIT cycle. Required: i_address=0x0001, HREADYOUT low for 2 cycles, HRDATA=0x12345678 when HREADYOUT=1.
- **Back-to-back:** write HADDR=0x3EC with 0xCD, then a read of 0x3EC presented in the DONE cycle. Required: second start exactly 1 cycle after DONE, and HRDATA=0x000000CD.
- **Errors:**
  - HSIZE=3'b000 at HADDR=0x8: HREADYOUT 0 then 1, with HRESP=1 for both cycles, no start, HRDATA unchanged.
  - HADDR=0x40000: same response.
  - HADDR=0x2 (misaligned): same response.
- **Idle/BUSY and deselect:** HTRANS=00, HTRANS=01, or HSEL=0 with HTRANS=10. Required: HREADYOUT stays 1 and no start is issued.
